// File: rtl/ans_ltf_pkg.sv
// Shared definitions for the obfuscated HT-LTF generator and its receive-side deobfuscator.
// The code-to-shift mapping lives here so that both directions read it from one place.
package ans_ltf_pkg;

   localparam int NFFT = 64;

   localparam logic [1:0] OBF_X1   = 2'b00;
   localparam logic [1:0] OBF_DIV8 = 2'b01;
   localparam logic [1:0] OBF_DIV2 = 2'b10;
   localparam logic [1:0] OBF_DIV4 = 2'b11;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_COLLECT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SGN_ZERO = 2'b00,
      SGN_POS  = 2'b01,
      SGN_NEG  = 2'b11
   } sign_t;

   // TX divides by 2^n, so RX restores by shifting left by the same n.
   function automatic logic [1:0] obf_shift(input logic [1:0] code);
      logic [1:0] sh;
      case (code)
         OBF_X1:   sh = 2'd0;
         OBF_DIV8: sh = 2'd3;
         OBF_DIV2: sh = 2'd1;
         default:  sh = 2'd2;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/ans_ht_ltf_sign_rom.sv
// 802.11n 20 MHz HT-LTF sign per FFT bin; bins 1..28 are k=+1..+28, bins 36..63 are k=-28..-1.
module ans_ht_ltf_sign_rom
   import ans_ltf_pkg::*;
(
   input  logic [5:0] bin,
   output sign_t      sign
);

   always_comb begin
      sign = SGN_POS;
      case (bin)
         6'd0, 6'd29, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35:
            sign = SGN_ZERO;
         6'd2, 6'd3, 6'd6, 6'd8, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14,
         6'd17, 6'd18, 6'd20, 6'd22, 6'd27, 6'd28,
         6'd40, 6'd41, 6'd44, 6'd46, 6'd53, 6'd54, 6'd57, 6'd59:
            sign = SGN_NEG;
         default:
            sign = SGN_POS;
      endcase
   end

endmodule

// File: rtl/ans_ht_ltf_deobf.sv
// Undoes per-bin obfuscation scaling on a received HT-LTF, strips the LTF sign and
// buffers the 64 channel estimates for random-access reads by the equalizer.
//
// state     | meaning
// S_IDLE    | waiting for fft_valid & fft_sync to start a symbol
// S_COLLECT | accepting bins cnt..63; sync here restarts at bin 0
module ans_ht_ltf_deobf
   import ans_ltf_pkg::*;
#(
   parameter int DW = 16
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [2*NFFT-1:0]   obf_coeff,
   input  logic [2*DW-1:0]     fft_data,
   input  logic                fft_valid,
   input  logic                fft_sync,
   input  logic [6:0]          addr,
   output logic [2*DW-1:0]     chan_est,
   output logic                est_ready,
   output logic                est_done,
   output logic                sync_err
);

   localparam logic [5:0]           LAST_BIN = 6'(NFFT - 1);
   localparam logic signed [DW-1:0] SMAX     = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] SMIN     = {1'b1, {(DW-1){1'b0}}};

   function automatic logic signed [DW-1:0] sat_shl(input logic signed [DW-1:0] x,
                                                    input logic [1:0] sh);
      logic signed [DW+2:0] w;
      w = {{3{x[DW-1]}}, x};
      w = w <<< sh;
      if ((&w[DW+2:DW-1]) || !(|w[DW+2:DW-1]))
         return w[DW-1:0];
      return w[DW+2] ? SMIN : SMAX;
   endfunction

   function automatic logic signed [DW-1:0] apply_sign(input logic signed [DW-1:0] x,
                                                       input sign_t s);
      case (s)
         SGN_POS: return x;
         SGN_NEG: return (x == SMIN) ? SMAX : -x;
         default: return '0;
      endcase
   endfunction

   state_t                state;
   logic [5:0]            cnt;
   logic [2*NFFT-1:0]     coeff_q;
   logic                  start;
   logic                  accept;
   logic [5:0]            bin;
   logic [2*NFFT-1:0]     cur_coeff;
   logic [1:0]            shamt;
   sign_t                 rom_sign;

   logic                  s1_valid;
   logic [5:0]            s1_bin;
   logic signed [DW-1:0]  s1_i;
   logic signed [DW-1:0]  s1_q;
   sign_t                 s1_sign;
   logic [2*DW-1:0]       mem [NFFT];

   logic                  unused_addr;
   assign unused_addr = addr[6];

   // Bin 0 of a new symbol must see the fresh obf_coeff, not the stale latch.
   always_comb begin
      start     = fft_valid && fft_sync;
      accept    = fft_valid && (fft_sync || (state == S_COLLECT));
      bin       = start ? 6'd0 : cnt;
      cur_coeff = start ? obf_coeff : coeff_q;
      shamt     = obf_shift(cur_coeff[{bin, 1'b0} +: 2]);
   end

   ans_ht_ltf_sign_rom u_sign_rom (
      .bin  (bin),
      .sign (rom_sign)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         s1_valid  <= 1'b0;
         est_ready <= 1'b0;
         est_done  <= 1'b0;
         sync_err  <= 1'b0;
         chan_est  <= '0;
      end else begin
         chan_est <= mem[addr[5:0]];
         s1_valid <= accept;
         sync_err <= start && (state == S_COLLECT);
         est_done <= s1_valid && (s1_bin == LAST_BIN);
         if (start)
            est_ready <= 1'b0;
         else if (s1_valid && (s1_bin == LAST_BIN))
            est_ready <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt   <= 6'd1;
                  state <= S_COLLECT;
               end
            end
            default: begin
               if (start) begin
                  cnt <= 6'd1;
               end else if (fft_valid) begin
                  if (cnt == LAST_BIN) begin
                     cnt   <= '0;
                     state <= S_IDLE;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (start)
         coeff_q <= obf_coeff;
      if (accept) begin
         s1_bin  <= bin;
         s1_i    <= sat_shl(fft_data[2*DW-1:DW], shamt);
         s1_q    <= sat_shl(fft_data[DW-1:0], shamt);
         s1_sign <= rom_sign;
      end
      if (s1_valid && !reset)
         mem[s1_bin] <= {apply_sign(s1_i, s1_sign), apply_sign(s1_q, s1_sign)};
   end

endmodule
